uart_tx: RTL and testbench

// - Serialising UART transmitter. Directly downstream of baud_generator: consumes its
//   one-clock baud_tick pulse (one pulse per bit period) and drives the serial tx line.
// - Accepts a parallel word over a valid/ready handshake and emits one asynchronous frame:

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_tx.sv | 121 ++++++++++++
 tb/tb_uart_tx.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes, default word width.
// Latency: n/a (constants and a pure helper function only).
// Backpressure: n/a; a future uart_rx imports the same package.
package uart_pkg;

    // Default number of data bits per frame (legal range 5..8)
    localparam int DEFAULT_DATA_BITS = 8;

    // Parity modes
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Transmitter / receiver FSM state encoding
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ALIGN  = 3'd1;
    localparam logic [2:0] ST_START  = 3'd2;
    localparam logic [2:0] ST_DATA   = 3'd3;
    localparam logic [2:0] ST_PARITY = 3'd4;
    localparam logic [2:0] ST_STOP   = 3'd5;

    // Frame length in bit periods, measured from the start edge
    function automatic int frame_periods(input int data_bits, input int parity, input int stop_bits);
        return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
    endfunction

endpackage

// File: rtl/uart_tx.sv
// Serialising UART transmitter: start, LSB-first data, optional parity, 1-2 stop bits.
// Latency: start edge on the first baud_tick after the handshake, then one period per bit.
// Backpressure: tx_ready only in IDLE; tx_valid/tx_data ignored while a frame is in flight.
module uart_tx
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS,
    parameter int PARITY    = PARITY_NONE,
    parameter int STOP_BITS = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam logic [2:0] LAST_BIT   = 3'(DATA_BITS - 1);
    localparam logic       LAST_STOP  = 1'(STOP_BITS - 1);
    localparam bit         HAS_PARITY = (PARITY != PARITY_NONE);
    localparam bit         ODD_PARITY = (PARITY == PARITY_ODD);

    logic [2:0]           state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [2:0]           bit_cnt;
    logic                 stop_cnt;
    logic                 parity_bit;
    logic                 accept;

    // Ready only in IDLE, and held low while reset is asserted
    assign tx_ready = (state == ST_IDLE) && !rst;
    assign accept   = tx_valid && tx_ready;

    // Frame sequencer: every line transition happens on a baud_tick edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            tx         <= 1'b1;
            tx_busy    <= 1'b0;
            shift_reg  <= '0;
            bit_cnt    <= '0;
            stop_cnt   <= 1'b0;
            parity_bit <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    tx <= 1'b1;
                    // A tick coinciding with the handshake is deliberately ignored;
                    // ALIGN waits for the next one so the start bit is a full period.
                    if (accept) begin
                        shift_reg  <= tx_data;
                        parity_bit <= ODD_PARITY ? ~^tx_data : ^tx_data;
                        bit_cnt    <= '0;
                        stop_cnt   <= 1'b0;
                        tx_busy    <= 1'b1;
                        state      <= ST_ALIGN;
                    end
                end
                ST_ALIGN: begin
                    if (baud_tick) begin
                        tx    <= 1'b0;
                        state <= ST_START;
                    end
                end
                ST_START: begin
                    if (baud_tick) begin
                        tx        <= shift_reg[0];
                        shift_reg <= shift_reg >> 1;
                        bit_cnt   <= '0;
                        state     <= ST_DATA;
                    end
                end
                ST_DATA: begin
                    // bit_cnt names the data bit currently on the line
                    if (baud_tick) begin
                        if (bit_cnt == LAST_BIT) begin
                            stop_cnt <= 1'b0;
                            if (HAS_PARITY) begin
                                tx    <= parity_bit;
                                state <= ST_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= ST_STOP;
                            end
                        end else begin
                            bit_cnt   <= bit_cnt + 3'd1;
                            tx        <= shift_reg[0];
                            shift_reg <= shift_reg >> 1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (baud_tick) begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (baud_tick) begin
                        if (stop_cnt == LAST_STOP) begin
                            tx_busy <= 1'b0;
                            state   <= ST_IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                    state   <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: five configurations share clk, rst and a baud_tick every 4 clk.
// Latency: frames are sampled mid-bit against a bit-list model built from the frame rules.
// Backpressure: handshakes wait on tx_ready with bounded loops; a global watchdog ends the run.
module tb_uart_tx;
    import uart_pkg::*;

    localparam int NDUT = 5;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic [7:0] data [NDUT];
    logic [NDUT-1:0] vld;
    logic [NDUT-1:0] rdy;
    logic [NDUT-1:0] txl;
    logic [NDUT-1:0] busy;

    int n_tests = 0;
    int n_fail  = 0;
    int tcnt    = 0;
    bit exp_q[$];

    always #5 clk = ~clk;

    // Bit-period strobe: one clk wide, every 4 clk, changed away from the active edge
    initial begin
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            tcnt++;
            baud_tick = (tcnt % 4 == 0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    uart_tx #(.DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1)) u0 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data[0]),
        .tx_valid(vld[0]), .tx_ready(rdy[0]), .tx(txl[0]), .tx_busy(busy[0]));
    uart_tx #(.DATA_BITS(8), .PARITY(PARITY_EVEN), .STOP_BITS(1)) u1 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data[1]),
        .tx_valid(vld[1]), .tx_ready(rdy[1]), .tx(txl[1]), .tx_busy(busy[1]));
    uart_tx #(.DATA_BITS(8), .PARITY(PARITY_ODD), .STOP_BITS(1)) u2 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data[2]),
        .tx_valid(vld[2]), .tx_ready(rdy[2]), .tx(txl[2]), .tx_busy(busy[2]));
    uart_tx #(.DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(2)) u3 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data[3]),
        .tx_valid(vld[3]), .tx_ready(rdy[3]), .tx(txl[3]), .tx_busy(busy[3]));
    uart_tx #(.DATA_BITS(5), .PARITY(PARITY_ODD), .STOP_BITS(2)) u4 (
        .clk(clk), .rst(rst), .baud_tick(baud_tick), .tx_data(data[4][4:0]),
        .tx_valid(vld[4]), .tx_ready(rdy[4]), .tx(txl[4]), .tx_busy(busy[4]));

    function automatic int db_of(int idx);
        return (idx == 4) ? 5 : 8;
    endfunction

    function automatic int par_of(int idx);
        case (idx)
            1:       return PARITY_EVEN;
            2, 4:    return PARITY_ODD;
            default: return PARITY_NONE;
        endcase
    endfunction

    function automatic int stop_of(int idx);
        return (idx >= 3) ? 2 : 1;
    endfunction

    task automatic check(string tag, int got, int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Reference: the list of line levels, one per bit period, starting at the start bit
    function automatic void build_frame(int idx, logic [7:0] d);
        int ones = 0;
        exp_q.delete();
        exp_q.push_back(1'b0);
        for (int i = 0; i < db_of(idx); i++) begin
            exp_q.push_back(d[i]);
            ones += int'(d[i]);
        end
        if (par_of(idx) == PARITY_EVEN)
            exp_q.push_back(bit'(ones % 2));
        else if (par_of(idx) == PARITY_ODD)
            exp_q.push_back(bit'(1 - (ones % 2)));
        for (int s = 0; s < stop_of(idx); s++)
            exp_q.push_back(1'b1);
    endfunction

    // Called at a negedge; returns at the negedge after the handshake edge
    task automatic send(int idx, logic [7:0] d, bit hold, logic [7:0] after_d);
        bit ok = 1'b0;
        data[idx] = d;
        vld[idx]  = 1'b1;
        for (int k = 0; k < 40 && !ok; k++) begin
            if (rdy[idx]) ok = 1'b1;
            else @(negedge clk);
        end
        check($sformatf("hs_ready_dut%0d", idx), int'(ok), 1);
        @(negedge clk);
        vld[idx]  = hold;
        data[idx] = after_d;
    endtask

    task automatic wait_start(int idx, output int cnt, output bit found);
        cnt   = 0;
        found = 1'b0;
        while (cnt < 24 && !found) begin
            if (txl[idx] == 1'b0) found = 1'b1;
            else begin
                @(negedge clk);
                cnt++;
            end
        end
    endtask

    // Samples every bit mid-period, then the ready/busy edge at the end of the last stop bit
    task automatic watch_frame(int idx, int exp_gap, string tag);
        int cnt;
        bit found;
        wait_start(idx, cnt, found);
        check({tag, "_start_seen"}, int'(found), 1);
        if (!found) return;
        if (exp_gap >= 0) check({tag, "_gap"}, cnt, exp_gap);
        repeat (2) @(negedge clk);
        foreach (exp_q[i]) begin
            if (i > 0) repeat (4) @(negedge clk);
            check($sformatf("%s_bit%0d", tag, i), int'(txl[idx]), int'(exp_q[i]));
            check($sformatf("%s_busy%0d", tag, i), int'(busy[idx]), 1);
            check($sformatf("%s_rdy%0d", tag, i), int'(rdy[idx]), 0);
        end
        @(negedge clk);
        check({tag, "_busy_last"}, int'(busy[idx]), 1);
        check({tag, "_rdy_last"}, int'(rdy[idx]), 0);
        @(negedge clk);
        check({tag, "_rdy_after"}, int'(rdy[idx]), 1);
        check({tag, "_busy_after"}, int'(busy[idx]), 0);
    endtask

    initial begin
        int  cnt;
        bit  found;
        bit  stayed_high;
        logic [7:0] d;

        rst = 1'b1;
        vld = '0;
        for (int i = 0; i < NDUT; i++) data[i] = 8'h00;

        // Reset held for three clocks
        repeat (3) @(negedge clk);
        for (int i = 0; i < NDUT; i++) begin
            check($sformatf("rst_tx_dut%0d", i), int'(txl[i]), 1);
            check($sformatf("rst_busy_dut%0d", i), int'(busy[i]), 0);
            check($sformatf("rst_rdy_dut%0d", i), int'(rdy[i]), 0);
        end
        rst = 1'b0;
        #1;
        for (int i = 0; i < NDUT; i++)
            check($sformatf("post_rst_rdy_dut%0d", i), int'(rdy[i]), 1);
        @(negedge clk);

        // Directed frames
        send(0, 8'h55, 1'b0, 8'($urandom));
        build_frame(0, 8'h55);
        watch_frame(0, -1, "d55");

        send(1, 8'h07, 1'b0, 8'($urandom));
        build_frame(1, 8'h07);
        watch_frame(1, -1, "even07");

        send(2, 8'h07, 1'b0, 8'($urandom));
        build_frame(2, 8'h07);
        watch_frame(2, -1, "odd07");

        send(3, 8'hFF, 1'b0, 8'($urandom));
        build_frame(3, 8'hFF);
        watch_frame(3, -1, "stop2_ff");

        // Back-to-back with valid held and data changed mid-frame
        send(0, 8'hA5, 1'b1, 8'h3C);
        build_frame(0, 8'hA5);
        watch_frame(0, -1, "b2b_a5");
        @(negedge clk);
        check("b2b_accept", int'(rdy[0]), 0);
        vld[0]  = 1'b0;
        data[0] = 8'($urandom);
        build_frame(0, 8'h3C);
        watch_frame(0, 3, "b2b_3c");

        // Reset in the middle of data bit 3
        send(0, 8'hC3, 1'b0, 8'($urandom));
        wait_start(0, cnt, found);
        check("rstmid_start_seen", int'(found), 1);
        repeat (17) @(negedge clk);
        check("rstmid_bit3", int'(txl[0]), 0);
        rst = 1'b1;
        #1;
        check("rstmid_rdy_in_rst", int'(rdy[0]), 0);
        @(negedge clk);
        check("rstmid_tx", int'(txl[0]), 1);
        check("rstmid_busy", int'(busy[0]), 0);
        check("rstmid_rdy_held", int'(rdy[0]), 0);
        rst = 1'b0;
        #1;
        check("rstmid_rdy_release", int'(rdy[0]), 1);
        stayed_high = 1'b1;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (txl[0] !== 1'b1) stayed_high = 1'b0;
        end
        check("rstmid_no_resend", int'(stayed_high), 1);
        send(0, 8'h81, 1'b0, 8'($urandom));
        build_frame(0, 8'h81);
        watch_frame(0, -1, "after_rst_81");

        // Randomised words on every configuration, random tick phase at handshake
        for (int r = 0; r < 8; r++) begin
            for (int idx = 0; idx < NDUT; idx++) begin
                repeat ($urandom_range(0, 5)) @(negedge clk);
                d = 8'($urandom);
                send(idx, d, 1'b0, 8'($urandom));
                build_frame(idx, d);
                watch_frame(idx, -1, $sformatf("rnd%0d_dut%0d", r, idx));
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
